// File: rtl/tristate_pkg.sv
// Shared types and helpers for tristate bus controllers: FSM states,
// parameter legality checks, index width and one-hot encoding.
package tristate_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_GRANT = 2'd1,
      ST_TURN  = 2'd2
   } state_e;

   localparam int unsigned MAX_REQ      = 16;
   localparam int unsigned HOLD_W       = 8;
   localparam int unsigned TURN_W       = 3;
   localparam int unsigned MIN_REQ      = 2;
   localparam int unsigned MAX_TURN     = 7;
   localparam int unsigned MAX_HOLD_LIM = 255;

   function automatic int unsigned idx_w(input int unsigned n);
      return (n < 2) ? 1 : $clog2(n);
   endfunction

   function automatic bit params_ok(input int unsigned n,
                                    input int unsigned ta,
                                    input int unsigned mh);
      return (n >= MIN_REQ) && (n <= MAX_REQ) &&
             (ta >= 1) && (ta <= MAX_TURN) &&
             (mh >= 1) && (mh <= MAX_HOLD_LIM);
   endfunction

   function automatic logic [MAX_REQ-1:0] onehot(input logic [3:0] idx);
      return MAX_REQ'(1) << idx;
   endfunction

endpackage

// File: rtl/tristate_bus_arbiter_rr_pick.sv
// Combinational round-robin picker: first set request at or above the
// pointer, wrapping modulo N.
module rr_pick
   import tristate_pkg::*;
#(
   parameter int unsigned N  = 4,
   parameter int unsigned IW = idx_w(N)
) (
   input  logic [N-1:0]  req_i,
   input  logic [IW-1:0] ptr_i,
   output logic [IW-1:0] idx_c,
   output logic          found_c
);

   int unsigned pos;

   always_comb begin
      found_c = 1'b0;
      idx_c   = '0;
      pos     = 0;
      for (int unsigned k = 0; k < N; k++) begin
         pos = (32'(ptr_i) + k) % N;
         if (!found_c && req_i[IW'(pos)]) begin
            found_c = 1'b1;
            idx_c   = IW'(pos);
         end
      end
   end

endmodule

// File: rtl/tristate_bus_arbiter.sv
// Round-robin owner selection for a shared tristate bus: one-hot drive
// enables, dead cycles between owners, and hold-limit preemption.
module tristate_bus_arbiter
   import tristate_pkg::*;
#(
   parameter int unsigned N_REQ      = 4,
   parameter int unsigned TURNAROUND = 1,
   parameter int unsigned MAX_HOLD   = 16
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic [N_REQ-1:0]           req,
   output logic [N_REQ-1:0]           grant,
   output logic [idx_w(N_REQ)-1:0]    owner,
   output logic                       busy,
   output logic                       preempt
);

   localparam int unsigned IW = idx_w(N_REQ);

   generate
      if (!params_ok(N_REQ, TURNAROUND, MAX_HOLD)) begin : g_bad_params
         $error("tristate_bus_arbiter: parameter out of range");
      end
   endgenerate

   state_e              state_q, state_d;
   logic [IW-1:0]       ptr_q, ptr_d;
   logic [HOLD_W-1:0]   hold_q, hold_d;
   logic [TURN_W-1:0]   turn_q, turn_d;
   logic [N_REQ-1:0]    grant_q, grant_d;
   logic [IW-1:0]       owner_q, owner_d;
   logic                busy_q, busy_d;
   logic                preempt_q, preempt_d;

   logic [IW-1:0]       pick_idx;
   logic                pick_found;

   rr_pick #(.N(N_REQ), .IW(IW)) u_pick (
      .req_i   (req),
      .ptr_i   (ptr_q),
      .idx_c   (pick_idx),
      .found_c (pick_found)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= ST_IDLE;
         ptr_q     <= '0;
         hold_q    <= '0;
         turn_q    <= '0;
         grant_q   <= '0;
         owner_q   <= '0;
         busy_q    <= 1'b0;
         preempt_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         ptr_q     <= ptr_d;
         hold_q    <= hold_d;
         turn_q    <= turn_d;
         grant_q   <= grant_d;
         owner_q   <= owner_d;
         busy_q    <= busy_d;
         preempt_q <= preempt_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      ptr_d     = ptr_q;
      hold_d    = hold_q;
      turn_d    = turn_q;
      grant_d   = grant_q;
      owner_d   = owner_q;
      busy_d    = busy_q;
      preempt_d = 1'b0;

      // Shared by IDLE and the final TURN edge: grant the round-robin pick.
      if ((state_q == ST_IDLE) ||
          ((state_q == ST_TURN) && (turn_q == TURN_W'(TURNAROUND)))) begin
         if (pick_found) begin
            state_d = ST_GRANT;
            grant_d = N_REQ'(onehot(4'(pick_idx)));
            owner_d = pick_idx;
            busy_d  = 1'b1;
            hold_d  = HOLD_W'(1);
            ptr_d   = (pick_idx == IW'(N_REQ - 1)) ? '0 : pick_idx + IW'(1);
         end else begin
            state_d = ST_IDLE;
         end
      end

      case (state_q)
         ST_GRANT: begin
            if (!req[owner_q]) begin
               state_d = ST_TURN;
               grant_d = '0;
               busy_d  = 1'b0;
               turn_d  = TURN_W'(1);
            end else if ((hold_q == HOLD_W'(MAX_HOLD)) && ((req & ~grant_q) != '0)) begin
               state_d   = ST_TURN;
               grant_d   = '0;
               busy_d    = 1'b0;
               turn_d    = TURN_W'(1);
               preempt_d = 1'b1;
            end else if (hold_q != HOLD_W'(MAX_HOLD)) begin
               hold_d = hold_q + HOLD_W'(1);
            end
         end
         ST_TURN: begin
            if (turn_q != TURN_W'(TURNAROUND)) begin
               turn_d = turn_q + TURN_W'(1);
            end
         end
         default: ;
      endcase
   end

   assign grant   = grant_q;
   assign owner   = owner_q;
   assign busy    = busy_q;
   assign preempt = preempt_q;

endmodule
